// File: rtl/fir_engine_mc.sv
// Time-multiplexed multi-channel FIR core.
// One serially loaded coefficient bank and one MAC are shared by Channels
// independent delay lines. Each accepted sample takes NTaps+2 cycles:
// one accept cycle, NTaps MAC cycles and one output/saturation cycle.

// Per-channel delay line: shifts the new sample into tap 0 on shift_en.
module fir_engine_mc_dline #(
    parameter int DataWidth = 12,
    parameter int NTaps     = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                shift_en,
    input  logic [DataWidth-1:0]                din,
    output logic [NTaps-1:0][DataWidth-1:0]     taps
);

    logic [NTaps-1:0][DataWidth-1:0] taps_q;
    logic [NTaps-1:0][DataWidth-1:0] taps_d;

    // Next delay-line contents: older samples move one tap further out.
    always_comb begin
        taps_d = taps_q;
        if (shift_en) begin
            taps_d = {taps_q[NTaps-2:0], din};
        end
    end

    // Delay-line storage, cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            taps_q <= '0;
        end else begin
            taps_q <= taps_d;
        end
    end

    assign taps = taps_q;

endmodule

// Shared-MAC FIR engine with saturation, bypass, coefficient chain and overrun flag.
module fir_engine_mc #(
    parameter int DataWidth  = 12,
    parameter int CoeffWidth = 12,
    parameter int NTaps      = 8,
    parameter int Channels   = 2,
    parameter int ChWidth    = (Channels > 1) ? $clog2(Channels) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [ChWidth-1:0]          ch,
    input  logic signed [DataWidth-1:0] x,
    input  logic                        bypass,
    input  logic                        lock,
    input  logic                        coeff_load_in,
    input  logic                        coeff_in,
    output logic                        coeff_out,
    output logic                        busy,
    output logic                        done,
    output logic signed [DataWidth-1:0] y,
    output logic [ChWidth-1:0]          y_ch,
    output logic                        sat,
    output logic                        overrun
);

    localparam int AccWidth  = DataWidth + CoeffWidth + $clog2(NTaps);
    localparam int ProdWidth = DataWidth + CoeffWidth;
    localparam int TapWidth  = $clog2(NTaps);
    localparam int CBits     = NTaps * CoeffWidth;

    // Clamp limits expressed at accumulator width so comparisons stay signed.
    localparam logic signed [AccWidth-1:0] YMax = AccWidth'((1 <<< (DataWidth - 1)) - 1);
    localparam logic signed [AccWidth-1:0] YMin = ~YMax;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Coefficient shift chain
    // ------------------------------------------------------------------
    logic [CBits-1:0]                    c_q;
    logic [CBits-1:0]                    c_d;
    logic [NTaps-1:0][CoeffWidth-1:0]    coeff;

    // Shift one bit in MSB-first, only while the update window is open.
    always_comb begin
        c_d = c_q;
        if (coeff_load_in && lock) begin
            c_d = {c_q[CBits-2:0], coeff_in};
        end
    end

    // Coefficient bank register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            c_q <= '0;
        end else begin
            c_q <= c_d;
        end
    end

    // Packed-array view with the same bit layout: coeff[k] = C[k*CoeffWidth +: CoeffWidth].
    assign coeff     = c_q;
    assign coeff_out = c_q[CBits-1];

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_t                          state_q, state_d;
    logic [TapWidth-1:0]             tap_q, tap_d;
    logic signed [AccWidth-1:0]      acc_q, acc_d;
    logic [ChWidth-1:0]              ch_q, ch_d;
    logic                            byp_q, byp_d;
    logic signed [DataWidth-1:0]     x_q, x_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic signed [DataWidth-1:0]     y_q, y_d;
    logic [ChWidth-1:0]              y_ch_q, y_ch_d;
    logic                            sat_q, sat_d;
    logic                            overrun_q, overrun_d;

    logic                            ch_ok;
    logic                            accept;

    assign ch_ok  = int'(ch) < Channels;
    assign accept = start && !lock && ch_ok && (state_q == IDLE);

    // ------------------------------------------------------------------
    // Delay lines, one per channel; only the addressed channel shifts.
    // ------------------------------------------------------------------
    logic [Channels-1:0]                             shift_en;
    logic [Channels-1:0][NTaps-1:0][DataWidth-1:0]   taps_all;

    for (genvar g = 0; g < Channels; g++) begin : g_ch
        assign shift_en[g] = accept && (int'(ch) == g);

        fir_engine_mc_dline #(
            .DataWidth (DataWidth),
            .NTaps     (NTaps)
        ) u_dline (
            .clk      (clk),
            .reset    (reset),
            .shift_en (shift_en[g]),
            .din      (x),
            .taps     (taps_all[g])
        );
    end

    // ------------------------------------------------------------------
    // Datapath: one tap product per MAC cycle, then shift/clamp.
    // ------------------------------------------------------------------
    logic signed [DataWidth-1:0]     d_sel;
    logic signed [CoeffWidth-1:0]    c_sel;
    logic signed [ProdWidth-1:0]     prod;
    logic signed [AccWidth-1:0]      prod_ext;
    logic signed [AccWidth-1:0]      acc_shr;

    assign d_sel    = taps_all[ch_q][tap_q];
    assign c_sel    = coeff[tap_q];
    assign prod     = d_sel * c_sel;
    assign prod_ext = {{(AccWidth - ProdWidth){prod[ProdWidth-1]}}, prod};
    // Arithmetic shift drops the Q1.(CoeffWidth-1) fraction, rounding toward -inf.
    assign acc_shr  = acc_q >>> (CoeffWidth - 1);

    // Next-state and output logic for IDLE -> MAC -> OUT -> IDLE.
    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        acc_d     = acc_q;
        ch_d      = ch_q;
        byp_d     = byp_q;
        x_d       = x_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        y_d       = y_q;
        y_ch_d    = y_ch_q;
        sat_d     = sat_q;
        overrun_d = overrun_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    ch_d    = ch;
                    byp_d   = bypass;
                    x_d     = x;
                    acc_d   = '0;
                    tap_d   = '0;
                    busy_d  = 1'b1;
                    state_d = MAC;
                end
            end
            MAC: begin
                if (lock) begin
                    // Coefficient update window opened: abandon this sample.
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    acc_d = acc_q + prod_ext;
                    tap_d = tap_q + 1'b1;
                    if (tap_q == TapWidth'(NTaps - 1)) begin
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                if (lock) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    if (byp_q) begin
                        y_d   = x_q;
                        sat_d = 1'b0;
                    end else if (acc_shr > YMax) begin
                        y_d   = YMax[DataWidth-1:0];
                        sat_d = 1'b1;
                    end else if (acc_shr < YMin) begin
                        y_d   = YMin[DataWidth-1:0];
                        sat_d = 1'b1;
                    end else begin
                        y_d   = acc_shr[DataWidth-1:0];
                        sat_d = 1'b0;
                    end
                    y_ch_d  = ch_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        // A valid start that arrives while the engine is occupied is lost.
        if (start && !lock && ch_ok && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // FSM and result registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            tap_q     <= '0;
            acc_q     <= '0;
            ch_q      <= '0;
            byp_q     <= 1'b0;
            x_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            y_q       <= '0;
            y_ch_q    <= '0;
            sat_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            acc_q     <= acc_d;
            ch_q      <= ch_d;
            byp_q     <= byp_d;
            x_q       <= x_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            y_q       <= y_d;
            y_ch_q    <= y_ch_d;
            sat_q     <= sat_d;
            overrun_q <= overrun_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign y       = y_q;
    assign y_ch    = y_ch_q;
    assign sat     = sat_q;
    assign overrun = overrun_q;

endmodule

// File: doc/fir_engine_mc.md
Name: fir_engine_mc

Overview:
- Time-multiplexed, multi-channel FIR core. Successor to the single-channel fir used by the FIR engine top.
- One shared serially-loaded coefficient bank and one MAC serve Channels independent delay lines (e.g. I2S left/right).
- Adds signed saturation, per-sample bypass mode, a coefficient daisy-chain output and a sticky overrun flag.
- Sits between the I2S controller (adcData/adcDataValid) and the DAC path. The coefficient chain is fed from the config store serial output.

Parameters:
- DataWidth, 12, signed sample width (in and out).
- CoeffWidth, 12, signed coefficient width, Q1.(CoeffWidth-1).
- NTaps, 8, taps per channel (>=2).
- Channels, 2, independent delay lines (>=1).
- ChWidth, max(1,$clog2(Channels)), derived, channel index width.
- AccWidth, DataWidth+CoeffWidth+$clog2(NTaps), derived, accumulator width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle strobe: sample x for channel ch is valid.
- ch  in  ChWidth  channel index of x.
- x  in  DataWidth  signed input sample.
- bypass  in  1  sampled with start; 1 = output x unfiltered.
- lock  in  1  1 = coefficient update window; starts ignored, running computation aborted.
- coeff_load_in  in  1  serial coefficient shift enable.
- coeff_in  in  1  serial coefficient bit.
- coeff_out  out  1  MSB of coefficient chain, for daisy-chaining.
- busy  out  1  computation in progress.
- done  out  1  one-cycle strobe: y/y_ch valid.
- y  out  DataWidth  signed filtered, saturated result.
- y_ch  out  ChWidth  channel of y.
- sat  out  1  y was clipped; valid with done, held until the next done.
- overrun  out  1  sticky: a start was dropped.

Behaviour:
- Reset (reset==0 at clk edge) clears:
  - all coefficients and all delay lines to 0;
  - busy, done, y, y_ch, sat, overrun, coeff_out to 0;
  - FSM to IDLE.
- Reset mid-computation aborts immediately with no done.
- Coefficient storage:
  - Flat vector C[NTaps*CoeffWidth-1:0], with coeff[k]=C[k*CoeffWidth +: CoeffWidth].
  - When coeff_load_in==1 and lock==1: C <= {C[msb-1:0], coeff_in}. coeff_out = C[msb] and is registered.
  - Load is MSB-first. The first bit shifted lands in the MSB of coeff[NTaps-1] after NTaps*CoeffWidth shifts.
  - coeff_load_in with lock==0 is ignored.
- Delay lines: d[c][0..NTaps-1]. An accepted start on channel c does d[c][k]<=d[c][k-1] for k>0 and d[c][0]<=x. Other channels are untouched.
- Start acceptance: accepted only when FSM==IDLE, lock==0 and ch<Channels.
  - A start with ch>=Channels is ignored silently.
  - A start while busy sets overrun=1 (sticky until reset). The running computation is unaffected.
  - A start while lock==1 is ignored; overrun is unchanged.
- FSM IDLE -> MAC -> OUT -> IDLE:
  - IDLE: on accepted start, latch ch, bypass and x, shift the delay line, acc<=0, tap<=0, busy<=1, go to MAC.
  - MAC: one tap per cycle, acc += d[c][tap]*coeff[tap] (full-precision signed). Uses the updated delay line, so tap 0 is the new x. After tap NTaps-1, go to OUT.
  - OUT: r = acc>>>(CoeffWidth-1) (arithmetic shift, truncation toward -inf), clamped to [-2^(DataWidth-1), 2^(DataWidth-1)-1].
    - sat=1 if clamped, else 0.
    - If bypass latched: y=x latched, sat=0.
    - done<=1 for one cycle, busy<=0, go to IDLE.
- Latency: start sampled at edge 0 gives done high in the cycle after edge NTaps+1; busy is high across edges 1..NTaps+1.
- Throughput: one sample per NTaps+2 cycles. A start in the same cycle done is high is accepted (FSM is IDLE).
- y, y_ch and sat hold their value until the next done.
- lock rising while busy: FSM returns to IDLE next edge, busy<=0, no done. The delay-line update already performed is kept.

Test Plan:
- Reset: hold reset=0 for 2 cycles, release, start ch=0 x=100 -> done after 10 cycles (NTaps=8) with y=0, sat=0, all coefficients 0, overrun=0.
- Load: lock=1, shift 96 bits so that coeff[0]=0x400 and others 0, then lock=0; start ch=0 x=512 -> y=256, y_ch=0; coeff_out follows the chain MSB during the shift.
- Channel isolation and impulse: coeff[k]=0x100*(k+1). Send ch0 x=1000 and ch1 x=0, then 7 further zero samples on each -> ch1 y is always 0. ch0 y sequence: floor(1000*256*(k+1)/2048) = 125, 250, ..., 1000.
- Saturation: all coeffs 0x7FF, 8 starts ch0 x=2047 -> 8th result has raw 16368, y=2047, sat=1. The same with x=-2048 gives y=-2048, sat=1.
- Overrun/lock: start during busy -> single done, overrun=1 and stays 1. Raise lock at MAC cycle 3 -> busy=0 next cycle, no done.
- Bypass: bypass=1, coeffs nonzero, x=-37 on ch1 -> y=-37, y_ch=1, sat=0, done at the same latency. The next non-bypass sample on ch1 includes -37 in tap 1.
